// File: rtl/kmer_minhash_unit.sv
// MinHash signature over all k-mers of one DNA window, one k-mer per cycle.
// Optional canonical k-mer hashing is enabled by defining KMER_CANONICAL_EN.
module kmer_minhash_unit #(
  parameter int          WINDOW_SIZE = 128,
  parameter int          KMER_SIZE   = 16,
  parameter int          NUM_HASHES  = 4,
  parameter int          HASH_W      = 16,
  parameter int          ID_W        = 8,
  parameter logic [31:0] SEED        = 32'h7F4A7C15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*WINDOW_SIZE-1:0]     window_flat,
  input  logic [ID_W-1:0]              window_id,
  input  logic                         is_insert,
  input  logic                         ready_for_hashing,
  input  logic                         window_reset,
  output logic                         busy,
  output logic                         sig_valid,
  input  logic                         sig_ready,
  output logic [NUM_HASHES*HASH_W-1:0] signature,
  output logic [ID_W-1:0]              sig_window_id,
  output logic                         sig_is_insert,
  output logic                         hashing_is_done
);

  localparam int NUM_KMERS = WINDOW_SIZE - KMER_SIZE + 1;
  localparam int KB        = 2 * KMER_SIZE;
  localparam int WB        = 2 * WINDOW_SIZE;
  localparam int IDX_W     = $clog2(NUM_KMERS + 1);
  localparam int SW        = NUM_HASHES * HASH_W;

  localparam logic [31:0]      MULT = 32'h9E3779B1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KMERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HASH,
    S_DONE
  } state_t;

  state_t           state;
  logic [WB-1:0]    win_q;
  logic [KB-1:0]    kmer_q;
  logic [KB-1:0]    kmer0;
  logic [KB-1:0]    hash_in;
  logic [IDX_W-1:0] idx;
  logic [SW-1:0]    nxt_sig;

  function automatic logic [HASH_W-1:0] hash_fn(
    input logic [31:0] k,
    input int          j
  );
    logic [31:0] p;
    p = (k ^ (SEED * 32'(j + 1))) * MULT;
    return HASH_W'(p >> (32 - HASH_W));
  endfunction

  // First k-mer: base 0 lands in the most significant bit pair.
  always_comb begin
    kmer0 = '0;
    for (int i = 0; i < KMER_SIZE; i++) begin
      kmer0[2*(KMER_SIZE-1-i) +: 2] = window_flat[2*i +: 2];
    end
  end

`ifdef KMER_CANONICAL_EN
  logic [KB-1:0] rc_q;

  always_comb begin
    hash_in = (kmer_q < rc_q) ? kmer_q : rc_q;
  end
`else
  always_comb begin
    hash_in = kmer_q;
  end
`endif

  always_comb begin
    logic [HASH_W-1:0] h;
    nxt_sig = signature;
    for (int j = 0; j < NUM_HASHES; j++) begin
      h = hash_fn(32'(hash_in), j);
      if (h < signature[j*HASH_W +: HASH_W]) begin
        nxt_sig[j*HASH_W +: HASH_W] = h;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      sig_valid       <= 1'b0;
      hashing_is_done <= 1'b0;
      signature       <= '1;
      sig_window_id   <= '0;
      sig_is_insert   <= 1'b0;
      idx             <= '0;
      kmer_q          <= '0;
      win_q           <= '0;
`ifdef KMER_CANONICAL_EN
      rc_q            <= '0;
`endif
    end else begin
      hashing_is_done <= 1'b0;
      if (window_reset) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        sig_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (ready_for_hashing) begin
              win_q         <= window_flat >> KB;
              kmer_q        <= kmer0;
`ifdef KMER_CANONICAL_EN
              rc_q          <= ~window_flat[KB-1:0];
`endif
              sig_window_id <= window_id;
              sig_is_insert <= is_insert;
              signature     <= '1;
              idx           <= '0;
              busy          <= 1'b1;
              state         <= S_HASH;
            end
          end
          S_HASH: begin
            signature <= nxt_sig;
            kmer_q    <= {kmer_q[KB-3:0], win_q[1:0]};
`ifdef KMER_CANONICAL_EN
            rc_q      <= {~win_q[1:0], rc_q[KB-1:2]};
`endif
            win_q     <= win_q >> 2;
            idx       <= idx + 1'b1;
            if (idx == LAST) begin
              sig_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            if (sig_ready) begin
              sig_valid       <= 1'b0;
              hashing_is_done <= 1'b1;
              busy            <= 1'b0;
              state           <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kmer_minhash_unit.sv
// Directed bench for kmer_minhash_unit at default parameters.
// Expected signatures come from an independent base-array model.
module tb_kmer_minhash_unit;

  logic         clk;
  logic         rst;
  logic [255:0] window_flat;
  logic [7:0]   window_id;
  logic         is_insert;
  logic         ready_for_hashing;
  logic         window_reset;
  logic         busy;
  logic         sig_valid;
  logic         sig_ready;
  logic [63:0]  signature;
  logic [7:0]   sig_window_id;
  logic         sig_is_insert;
  logic         hashing_is_done;

  int errs;
  int checks;

  kmer_minhash_unit dut (
    .clk              (clk),
    .rst              (rst),
    .window_flat      (window_flat),
    .window_id        (window_id),
    .is_insert        (is_insert),
    .ready_for_hashing(ready_for_hashing),
    .window_reset     (window_reset),
    .busy             (busy),
    .sig_valid        (sig_valid),
    .sig_ready        (sig_ready),
    .signature        (signature),
    .sig_window_id    (sig_window_id),
    .sig_is_insert    (sig_is_insert),
    .hashing_is_done  (hashing_is_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] h_ref(
    input logic [31:0] k,
    input int          j
  );
    logic [31:0] s;
    logic [31:0] p;
    s = 32'h7F4A7C15 * 32'(j + 1);
    p = (k ^ s) * 32'h9E3779B1;
    return p[31:16];
  endfunction

  function automatic logic [63:0] model_sig(input logic [255:0] w);
    logic [1:0]  b [128];
    logic [31:0] fwd;
    logic [31:0] rc;
    logic [31:0] k;
    logic [15:0] h;
    logic [63:0] m;
    for (int i = 0; i < 128; i++) b[i] = w[2*i +: 2];
    m = '1;
    for (int p = 0; p <= 112; p++) begin
      fwd = '0;
      rc  = '0;
      for (int i = 0; i < 16; i++) fwd = (fwd << 2) | 32'(b[p+i]);
      for (int i = 15; i >= 0; i--) rc = (rc << 2) | 32'(~b[p+i]);
`ifdef KMER_CANONICAL_EN
      k = (rc < fwd) ? rc : fwd;
`else
      k = fwd;
`endif
      for (int j = 0; j < 4; j++) begin
        h = h_ref(k, j);
        if (h < m[16*j +: 16]) m[16*j +: 16] = h;
      end
    end
    return m;
  endfunction

  // Accepts one window and waits (bounded) for sig_valid.
  task automatic run_win(
    input  logic [255:0] w,
    input  logic [7:0]   id,
    input  logic         ins,
    output logic [63:0]  sig,
    output int           lat
  );
    window_flat       = w;
    window_id         = id;
    is_insert         = ins;
    ready_for_hashing = 1'b1;
    step();
    ready_for_hashing = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!sig_valid && lat < 300);
    sig = signature;
  endtask

  logic [255:0] w;
  logic [63:0]  sig;
  logic [63:0]  sig_a;
  logic [63:0]  sig_t;
  int           lat;
  int           nv;
  int           nd;

  initial begin
    errs              = 0;
    checks            = 0;
    rst               = 1'b1;
    window_flat       = '0;
    window_id         = '0;
    is_insert         = 1'b0;
    ready_for_hashing = 1'b0;
    window_reset      = 1'b0;
    sig_ready         = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(sig_valid), 64'd0);
    chk("rst_done", 64'(hashing_is_done), 64'd0);
    chk("rst_sig", signature, '1);
    chk("rst_id", 64'(sig_window_id), 64'd0);
    chk("rst_ins", 64'(sig_is_insert), 64'd0);

    // All-A window with downstream always ready
    sig_ready = 1'b1;
    run_win('0, 8'h05, 1'b1, sig_a, lat);
    chk("a_latency", 64'(lat), 64'd113);
    chk("a_sig", sig_a, {h_ref(0, 3), h_ref(0, 2), h_ref(0, 1), h_ref(0, 0)});
    chk("a_id", 64'(sig_window_id), 64'h05);
    chk("a_ins", 64'(sig_is_insert), 64'd1);
    chk("a_busy", 64'(busy), 64'd1);
    step();
    chk("a_done_hi", 64'(hashing_is_done), 64'd1);
    chk("a_valid_lo", 64'(sig_valid), 64'd0);
    chk("a_busy_lo", 64'(busy), 64'd0);
    step();
    chk("a_done_lo", 64'(hashing_is_done), 64'd0);

    // Random window, downstream stalls for 10 cycles
    sig_ready = 1'b0;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    run_win(w, 8'h3C, 1'b0, sig, lat);
    chk("r_latency", 64'(lat), 64'd113);
    chk("r_sig", sig, model_sig(w));
    chk("r_id", 64'(sig_window_id), 64'h3C);
    chk("r_ins", 64'(sig_is_insert), 64'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("stall_valid", 64'(sig_valid), 64'd1);
      chk("stall_done", 64'(hashing_is_done), 64'd0);
      chk("stall_sig", signature, model_sig(w));
    end
    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
    chk("r_done_hi", 64'(hashing_is_done), 64'd1);
    step();

    // Abort at HASH cycle 50
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    window_flat       = w;
    window_id         = 8'h11;
    ready_for_hashing = 1'b1;
    step();
    ready_for_hashing = 1'b0;
    for (int c = 0; c < 50; c++) step();
    chk("ab_busy_pre", 64'(busy), 64'd1);
    window_reset = 1'b1;
    sig_ready    = 1'b1;
    step();
    window_reset = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    nv = 0;
    nd = 0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (sig_valid) nv++;
      if (hashing_is_done) nd++;
    end
    chk("ab_no_valid", 64'(nv), 64'd0);
    chk("ab_no_done", 64'(nd), 64'd0);
    sig_ready = 1'b0;

    // Next window, with ready_for_hashing kept high during HASH
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    window_flat       = w;
    window_id         = 8'h77;
    is_insert         = 1'b1;
    ready_for_hashing = 1'b1;
    step();
    window_flat = ~w;
    window_id   = 8'h99;
    is_insert   = 1'b0;
    lat         = 0;
    do begin
      step();
      lat++;
    end while (!sig_valid && lat < 300);
    ready_for_hashing = 1'b0;
    chk("ig_latency", 64'(lat), 64'd113);
    chk("ig_sig", signature, model_sig(w));
    chk("ig_id", 64'(sig_window_id), 64'h77);
    chk("ig_ins", 64'(sig_is_insert), 64'd1);

    // Reset while presenting a signature
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_busy", 64'(busy), 64'd0);
    chk("rd_valid", 64'(sig_valid), 64'd0);
    chk("rd_done", 64'(hashing_is_done), 64'd0);
    chk("rd_sig", signature, '1);
    chk("rd_id", 64'(sig_window_id), 64'd0);
    chk("rd_ins", 64'(sig_is_insert), 64'd0);

    // All-T versus all-A
    sig_ready = 1'b1;
    run_win('1, 8'h21, 1'b0, sig_t, lat);
    chk("t_sig", sig_t, model_sig('1));
    step();
    step();
    run_win('0, 8'h22, 1'b0, sig_a, lat);
    chk("a2_sig", sig_a, model_sig('0));
    step();
`ifdef KMER_CANONICAL_EN
    chk("ta_same", 64'(sig_t == sig_a), 64'd1);
`else
    chk("ta_differ", 64'(sig_t != sig_a), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
